// File: rtl/nibble_add_seq.sv
// ---------------------------------------------------------------------------
// nibble_add_seq
//
// Sequences a wide add (W = 4*NIBBLES bits) onto one shared, external 4-bit
// combinational adder. Each clock feeds the adder one nibble, starting with
// the least significant nibble. The nibble sum and carry come back in the
// same cycle and are registered. The finished result is flagged by a
// one-cycle done pulse.
//
// Parameters:
//   NIBBLES   number of 4-bit slices per operand (1..16)
//
// Optional build macro:
//   NIBBLE_ADD_SEQ_OVF_EN  adds output ovf, the two's-complement overflow
//                          of the W-bit add
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, accepted only in IDLE
//   a, b      in   W-bit operands, sampled on accept
//   c_in      in   carry-in, sampled on accept
//   busy      out  high while the nibble loop runs
//   done      out  one-cycle pulse, result valid
//   sum       out  W-bit result, held until next accept
//   c_out     out  carry out of the top nibble, held until next accept
//   ovf       out  (macro only) signed overflow, held with sum
//   add_x     out  nibble of A to the shared adder
//   add_y     out  nibble of B to the shared adder
//   add_cin   out  running carry to the shared adder
//   add_s     in   adder nibble sum (combinational, same cycle)
//   add_cout  in   adder carry out (combinational, same cycle)
// ---------------------------------------------------------------------------
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  output logic                 ovf,
`endif
  output logic [3:0]           add_x,
  output logic [3:0]           add_y,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);

  localparam int W    = 4 * NIBBLES;
  // The nibble index needs at least one bit, even when NIBBLES = 1.
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [W-1:0]    sum_reg, sum_next;
  logic            carry_reg, carry_next;
  logic            c_out_reg, c_out_next;
  logic [IDXW-1:0] idx_reg, idx_next;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic            ovf_reg, ovf_next;
`endif

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      idx_reg   <= '0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      c_out_reg <= c_out_next;
      idx_reg   <= idx_next;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and adder drive
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    c_out_next = c_out_reg;
    idx_next   = idx_reg;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    ovf_next   = ovf_reg;
`endif
    add_x      = 4'h0;
    add_y      = 4'h0;
    add_cin    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          a_next     = a;
          b_next     = b;
          carry_next = c_in;
          idx_next   = '0;
          // The previous result is dropped as soon as a new request is taken.
          sum_next   = '0;
          c_out_next = 1'b0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
          ovf_next   = 1'b0;
`endif
        end
      end

      RUN: begin
        // The loop decodes the index into constant slices. This avoids a
        // variable part-select whose offset width would depend on NIBBLES.
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_reg == IDXW'(i)) begin
            add_x                = a_reg[4*i +: 4];
            add_y                = b_reg[4*i +: 4];
            sum_next[4*i +: 4]   = add_s;
          end
        end
        add_cin    = carry_reg;
        carry_next = add_cout;
        idx_next   = idx_reg + 1'b1;

        if (idx_reg == IDXW'(NIBBLES - 1)) begin
          c_out_next = add_cout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
          // Signed overflow is the carry into the sign bit XOR the carry out
          // of it. The carry into bit W-1 is recovered as a ^ b ^ s at that
          // bit position.
          ovf_next   = add_cout ^ (a_reg[W-1] ^ b_reg[W-1] ^ add_s[3]);
`endif
          state_next = DONE;
        end
      end

      DONE: begin
        // Always return to IDLE. A start seen here is not queued.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: status is a decode of the registered state, and results come
  // straight from their holding registers.
  // -------------------------------------------------------------------------
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign sum   = sum_reg;
  assign c_out = c_out_reg;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  assign ovf   = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_add_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_add_seq
//
// Directed bench for nibble_add_seq with NIBBLES = 4. The shared 4-bit adder
// is modelled here as a plain combinational add. Expected results are worked
// out by hand in the stimulus below.
// ---------------------------------------------------------------------------
module tb_nibble_add_seq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        c_in = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic [15:0] sum;
  logic        busy, done, c_out;
  logic [3:0]  add_x, add_y, add_s;
  logic        add_cin, add_cout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  // State captured by do_op for the checks that follow it.
  logic [3:0]  xs[$];
  logic        cs[$];
  logic [15:0] sum_first;
  int          lat;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    .ovf      (ovf),
`endif
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Shared 4-bit ripple adder (external to the DUT).
  assign {add_cout, add_s} = 5'(add_x) + 5'(add_y) + 5'(add_cin);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Issue one request and run it to completion.
  // lat counts clock edges from the accept edge (which counts as 1) up to the
  // edge after which done is seen.
  // poke != 0 drives start high with a new operand at that lat value, and
  // releases it two cycles later, while the request is still running.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input int poke);
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the inputs once the operands have been taken.
    a = 16'hDEAD; b = 16'hBEEF; c_in = ~tc;
    lat = 1;
    xs.delete();
    cs.delete();
    while (1) begin
      @(negedge clk);
      if (lat == 1) sum_first = sum;
      if (done) break;
      if (lat > 20) begin
        check("done_timeout", {31'b0, done}, 32'd1);
        break;
      end
      if (busy) begin
        xs.push_back(add_x);
        cs.push_back(add_cin);
      end
      if (poke != 0 && lat == poke) begin
        start = 1'b1;
        a = 16'hFFFF;
      end
      if (poke != 0 && lat == poke + 2) start = 1'b0;
      @(posedge clk);
      lat++;
    end
    $display("op a=%04h b=%04h cin=%0d -> sum=%04h c_out=%0d lat=%0d", ta, tb_v, tc, sum, c_out, lat);
  endtask

  initial begin
    int dcnt;
    int bcnt;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'b0, busy},  32'd0);
    check("rst_done",  {31'b0, done},  32'd0);
    check("rst_sum",   {16'b0, sum},   32'h0);
    check("rst_c_out", {31'b0, c_out}, 32'd0);
    check("rst_add_x", {28'b0, add_x}, 32'd0);
    check("rst_add_y", {28'b0, add_y}, 32'd0);
    rst_n = 1'b1;

    // ---------------- 1 + 1 ----------------
    do_op(16'h0001, 16'h0001, 1'b0, 0);
    check("t1_latency", lat, 32'd5);
    check("t1_sum",   {16'b0, sum},   32'h0002);
    check("t1_c_out", {31'b0, c_out}, 32'd0);
    check("t1_busy_at_done", {31'b0, busy}, 32'd0);
    check("t1_xs_len", xs.size(), 32'd4);
    if (xs.size() == 4)
      check("t1_add_x_seq", {16'b0, xs[3], xs[2], xs[1], xs[0]}, 32'h0001);
    @(negedge clk);
    check("t1_done_pulse_1cyc", {31'b0, done}, 32'd0);
    check("t1_sum_held",  {16'b0, sum},   32'h0002);
    check("t1_idle_add_x", {28'b0, add_x}, 32'd0);

    // ---------------- FFFF + 0000 + 1 ----------------
    do_op(16'hFFFF, 16'h0000, 1'b1, 0);
    check("t2_sum_cleared_on_accept", {16'b0, sum_first}, 32'h0);
    check("t2_sum",   {16'b0, sum},   32'h0000);
    check("t2_c_out", {31'b0, c_out}, 32'd1);
    check("t2_cs_len", cs.size(), 32'd4);
    if (cs.size() == 4)
      check("t2_add_cin_seq", {28'b0, cs[3], cs[2], cs[1], cs[0]}, 32'hF);

    // ---------------- start while busy is ignored ----------------
    do_op(16'h1234, 16'h1111, 1'b0, 2);
    check("t3_latency", lat, 32'd5);
    check("t3_sum",   {16'b0, sum},   32'h2345);
    check("t3_c_out", {31'b0, c_out}, 32'd0);
    dcnt = 0;
    bcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("t3_no_extra_done", dcnt, 32'd0);
    check("t3_no_extra_busy", bcnt, 32'd0);
    check("t3_sum_held", {16'b0, sum}, 32'h2345);

    // ---------------- reset in the middle of RUN ----------------
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t4_partial_sum", {16'b0, sum}, 32'h0033);
    #1;
    rst_n = 1'b0;
    #1;
    check("t4_abort_busy", {31'b0, busy}, 32'd0);
    check("t4_abort_sum",  {16'b0, sum},  32'h0);
    check("t4_abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t4_no_done_after_abort", dcnt, 32'd0);
    $display("op abort after 2 RUN cycles -> sum=%04h busy=%0d", sum, busy);

    do_op(16'h00F0, 16'h0010, 1'b0, 0);
    check("t4_sum",   {16'b0, sum},   32'h0100);
    check("t4_c_out", {31'b0, c_out}, 32'd0);

    // ---------------- wrap-around and overflow ----------------
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    check("t5_sum",   {16'b0, sum},   32'h0000);
    check("t5_c_out", {31'b0, c_out}, 32'd1);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    check("t5_ovf", {31'b0, ovf}, 32'd0);
`endif
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    check("t6_sum",   {16'b0, sum},   32'h8000);
    check("t6_c_out", {31'b0, c_out}, 32'd0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    check("t6_ovf", {31'b0, ovf}, 32'd1);
`endif

    // ---------------- start held high continuously ----------------
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; c_in = 1'b0; start = 1'b1;
    dcnt = 0;
    while (!done && dcnt < 20) begin
      @(negedge clk);
      dcnt++;
    end
    check("t7_first_done", {31'b0, done}, 32'd1);
    check("t7_sum", {16'b0, sum}, 32'h0008);
    @(negedge clk);
    check("t7_idle_after_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("t7_reaccept_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    dcnt = 0;
    while (!done && dcnt < 20) begin
      @(negedge clk);
      dcnt++;
    end
    check("t7_second_done", {31'b0, done}, 32'd1);
    check("t7_second_sum", {16'b0, sum}, 32'h0008);
    $display("op held-start back-to-back -> sum=%04h", sum);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
